cond_logic: RTL and testbench

- Consumer end of the ALU flag interface in the multicycle ARM datapath.
- Registers the NZCV flags produced by the ALU and evaluates the 4-bit instruction condition field against the stored flags.
- Holds the condition result for the later FSM states, and gates the architectural write enables (PC, register file, memory) from the main controller.
- Sits between the main decoder/FSM and the datapath write ports.

---
 rtl/cond_logic_if.sv | 27 ++
 rtl/cond_logic.sv | 59 +++++
 tb/tb_cond_logic.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_logic_if.sv
// Flag/condition interface between the main controller (master) and the
// conditional-execution unit (slave).
interface cond_logic_if #(
    parameter int FLAG_W = 4
);
    logic [3:0]        Cond;
    logic [FLAG_W-1:0] ALUFlags;
    logic [1:0]        FlagW;
    logic              PCS;
    logic              NextPC;
    logic              RegW;
    logic              MemW;
    logic              PCWrite;
    logic              RegWrite;
    logic              MemWrite;
    logic [FLAG_W-1:0] Flags;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        input  PCWrite, RegWrite, MemWrite, Flags
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        output PCWrite, RegWrite, MemWrite, Flags
    );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds NZCV, evaluates the condition field and
// gates the architectural write enables of the multicycle datapath.
module cond_logic #(
    parameter int FLAG_W = 4
) (
    input logic          clk,
    input logic          reset,
    cond_logic_if.slave  bus
);
    logic [FLAG_W-1:0] flags;
    logic [1:0]        flagwrite;
    logic              condex;
    logic              condexd;
    logic              n, z, c, v;

    assign {n, z, c, v} = flags;

    // Evaluated from the stored flags only, so a concurrent flag write sees old flags.
    always_comb begin
        condex = 1'b1;
        case (bus.Cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            4'b1111: condex = 1'b1;
            default: condex = 1'b1;
        endcase
    end

    assign flagwrite = bus.FlagW & {2{condex}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags   <= '0;
            condexd <= 1'b0;
        end else begin
            if (flagwrite[1]) flags[3:2] <= bus.ALUFlags[3:2];
            if (flagwrite[0]) flags[1:0] <= bus.ALUFlags[1:0];
            condexd <= condex;
        end
    end

    assign bus.RegWrite = bus.RegW & condexd;
    assign bus.MemWrite = bus.MemW & condexd;
    assign bus.PCWrite  = (bus.PCS & condexd) | bus.NextPC;
    assign bus.Flags    = flags;
endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic against a behavioural NZCV/condition model.
module tb_cond_logic;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [3:0] mflags;
    logic       mcondexd;

    cond_logic_if #(.FLAG_W(4)) bus ();

    cond_logic #(.FLAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM condition: even codes select a base predicate, odd codes invert it.
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv, base;
        {fn, fz, fc, fv} = f;
        case (cc[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: return 1'b1;
        endcase
        return cc[0] ? !base : base;
    endfunction

    function automatic logic [6:0] expected_outputs();
        logic pcw;
        pcw = (bus.PCS && mcondexd) || bus.NextPC;
        return {mflags, pcw, bus.RegW & mcondexd, bus.MemW & mcondexd};
    endfunction

    task automatic step();
        logic ce;
        ce = ref_cond(bus.Cond, mflags);
        @(posedge clk);
        if (!reset) begin
            mflags   = 4'b0000;
            mcondexd = 1'b0;
        end else begin
            if (bus.FlagW[1] && ce) mflags[3:2] = bus.ALUFlags[3:2];
            if (bus.FlagW[0] && ce) mflags[1:0] = bus.ALUFlags[1:0];
            mcondexd = ce;
        end
        #1;
    endtask

    task automatic drive(input logic [3:0] cc, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic npc, input logic rw, input logic mw);
        bus.Cond     = cc;
        bus.ALUFlags = alu;
        bus.FlagW    = fw;
        bus.PCS      = pcs;
        bus.NextPC   = npc;
        bus.RegW     = rw;
        bus.MemW     = mw;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mflags = 4'b0000;
        mcondexd = 1'b0;
        drive(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        step();
        n_cmp++;
        if ({bus.Flags, bus.PCWrite, bus.RegWrite, bus.MemWrite} !== 7'b0000_000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {bus.Flags, bus.PCWrite, bus.RegWrite, bus.MemWrite}, 7'b0000_000);
        end
        bus.NextPC = 1'b1;
        #1;
        n_cmp++;
        if (bus.PCWrite !== 1'b1) begin
            n_err++;
            $display("FAIL reset_nextpc: PCWrite got %b expected 1", bus.PCWrite);
        end
        drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_flag_capture();
        drive(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (bus.Flags !== 4'b0100) begin
            n_err++;
            $display("FAIL capture_both: Flags got %b expected 0100", bus.Flags);
        end
        drive(4'b1110, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (bus.Flags !== 4'b1000) begin
            n_err++;
            $display("FAIL capture_nz_only: Flags got %b expected 1000", bus.Flags);
        end
        drive(4'b1110, 4'b0111, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (bus.Flags !== 4'b1011) begin
            n_err++;
            $display("FAIL capture_cv_only: Flags got %b expected 1011", bus.Flags);
        end
    endtask

    task automatic test_cond_sweep();
        logic [3:0] fvals [5];
        logic       exp;
        fvals = '{4'b0000, 4'b0100, 4'b0010, 4'b1001, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            drive(4'b1110, fvals[i], 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            n_cmp++;
            if (bus.Flags !== fvals[i]) begin
                n_err++;
                $display("FAIL sweep_setflags: Flags got %b expected %b", bus.Flags, fvals[i]);
            end
            for (int c = 0; c < 16; c++) begin
                drive(4'(c), 4'($urandom), 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
                step();
                exp = ref_cond(4'(c), fvals[i]);
                n_cmp++;
                if ({bus.PCWrite, bus.RegWrite, bus.MemWrite} !== {3{exp}}) begin
                    n_err++;
                    $display("FAIL sweep_cond: flags=%b cond=%b got %b expected %b",
                             fvals[i], 4'(c), {bus.PCWrite, bus.RegWrite, bus.MemWrite}, {3{exp}});
                end
            end
        end
    endtask

    task automatic test_failed_cond();
        drive(4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(4'b0000, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (bus.Flags !== 4'b0000) begin
            n_err++;
            $display("FAIL failed_cond_flags: Flags got %b expected 0000", bus.Flags);
        end
        drive(4'b0000, 4'b1111, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        n_cmp++;
        if ({bus.PCWrite, bus.RegWrite, bus.MemWrite} !== 3'b000) begin
            n_err++;
            $display("FAIL failed_cond_gate: got %b expected 000",
                     {bus.PCWrite, bus.RegWrite, bus.MemWrite});
        end
    endtask

    task automatic test_delayed_gating();
        drive(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        n_cmp++;
        if (bus.RegWrite !== 1'b1) begin
            n_err++;
            $display("FAIL delayed_eq: RegWrite got %b expected 1", bus.RegWrite);
        end
        bus.Cond = 4'b0001;
        #1;
        n_cmp++;
        if (bus.RegWrite !== 1'b1) begin
            n_err++;
            $display("FAIL delayed_lag: RegWrite got %b expected 1", bus.RegWrite);
        end
        step();
        n_cmp++;
        if (bus.RegWrite !== 1'b0) begin
            n_err++;
            $display("FAIL delayed_ne: RegWrite got %b expected 0", bus.RegWrite);
        end
    endtask

    task automatic test_mid_reset();
        drive(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        n_cmp++;
        if ({bus.Flags, bus.RegWrite} !== 5'b1111_1) begin
            n_err++;
            $display("FAIL midreset_pre: got %b expected 11111", {bus.Flags, bus.RegWrite});
        end
        #1;
        reset = 1'b0;
        mflags = 4'b0000;
        mcondexd = 1'b0;
        #1;
        n_cmp++;
        if ({bus.Flags, bus.RegWrite} !== 5'b0000_0) begin
            n_err++;
            $display("FAIL midreset_async: got %b expected 00000", {bus.Flags, bus.RegWrite});
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.RegWrite !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release: RegWrite got %b expected 0", bus.RegWrite);
        end
        step();
        n_cmp++;
        if (bus.RegWrite !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_resume: RegWrite got %b expected 1", bus.RegWrite);
        end
    endtask

    task automatic test_random();
        logic [6:0] exp;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom), 4'($urandom),
                  2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom), 1'($urandom));
            #1;
            exp = expected_outputs();
            n_cmp++;
            if ({bus.Flags, bus.PCWrite, bus.RegWrite, bus.MemWrite} !== exp) begin
                n_err++;
                $display("FAIL random_pre[%0d]: got %b expected %b", i,
                         {bus.Flags, bus.PCWrite, bus.RegWrite, bus.MemWrite}, exp);
            end
            step();
            exp = expected_outputs();
            n_cmp++;
            if ({bus.Flags, bus.PCWrite, bus.RegWrite, bus.MemWrite} !== exp) begin
                n_err++;
                $display("FAIL random_post[%0d]: got %b expected %b", i,
                         {bus.Flags, bus.PCWrite, bus.RegWrite, bus.MemWrite}, exp);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_flag_capture();
        test_cond_sweep();
        test_failed_cond();
        test_delayed_gating();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
